// File: rtl/tri_intersect_seq_if.sv
// tri_intersect_seq_if
// Request/result bundle between the ray generator, the intersection engine
// and the hit resolver.
//   slave  : engine side (accepts the request, drives the result)
//   master : tracer side (drives the request, consumes the result)
// Signals:
//   i_valid / o_ready   request handshake
//   i_triangle          corners [2]=C2 [1]=C1 [0]=C0, each [2]=x [1]=y [0]=z
//   i_ray               [1] origin E, [0] direction D, each [2]=x [1]=y [0]=z
//   o_valid / i_ready   result handshake
//   o_hit, o_invalid    result flags
//   o_a, o_b, o_t       barycentrics and distance, Q(W-FRAC).FRAC
interface tri_intersect_seq_if #(
  parameter int W = 32
);
  logic                   i_valid;
  logic                   o_ready;
  logic [2:0][2:0][W-1:0] i_triangle;
  logic [1:0][2:0][W-1:0] i_ray;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_hit;
  logic                   o_invalid;
  logic [W-1:0]           o_a;
  logic [W-1:0]           o_b;
  logic [W-1:0]           o_t;

  modport slave (
    input  i_valid, i_triangle, i_ray, i_ready,
    output o_ready, o_valid, o_hit, o_invalid, o_a, o_b, o_t
  );

  modport master (
    output i_valid, i_triangle, i_ray, i_ready,
    input  o_ready, o_valid, o_hit, o_invalid, o_a, o_b, o_t
  );
endinterface

// File: rtl/tri_intersect_seq.sv
// tri_intersect_seq
// Multi-cycle ray/triangle intersector. Solves
//   a*T1 + b*T2 + t*(-D) = E - C0
// by Cramer's rule with one shared 3x3 determinant datapath (one determinant
// per cycle) and one shared restoring divider (one quotient bit per cycle).
// Ports:
//   i_clk   clock, rising edge
//   i_rstn  asynchronous active-low reset
//   io_bus  tri_intersect_seq_if.slave (request in, result out)
// Parameters: W word width, FRAC fraction bits, MIN_T/MAX_T accepted t range.
// Optional feature macro: TRI_INTERSECT_CULL_EN (back-face culling, coef<0
// fails and exits early after the determinants).
//
// state  | meaning
// S_IDLE | o_ready high, waiting for a request
// S_DET  | four cycles, latch coef, da, db, dt
// S_DIV  | first cycle decides early exit, then a, b, t quotients
// S_DONE | o_valid high, result held until i_ready
module tri_intersect_seq #(
  parameter int                  W     = 32,
  parameter int                  FRAC  = 16,
  parameter logic signed [W-1:0] MIN_T = '0,
  parameter logic signed [W-1:0] MAX_T = {1'b0, {(W-1){1'b1}}}
) (
  input logic                i_clk,
  input logic                i_rstn,
  tri_intersect_seq_if.slave io_bus
);

  localparam int N  = W + FRAC;          // quotient bits per division
  localparam int SW = 3 * (W + 1) + 3;   // triple products plus 6-term sum growth
  localparam int CW = $clog2(N);
  localparam logic signed [W:0] ONE_Q = (W+1)'(1) << FRAC;

  typedef enum logic [1:0] {S_IDLE, S_DET, S_DIV, S_DONE} state_t;
  typedef logic signed [W:0] wide_t;

  function automatic wide_t sx(input logic [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic signed [SW-1:0] tp(input wide_t p, input wide_t q,
                                              input wide_t r);
    logic signed [SW-1:0] pe, qe, re;
    pe = p;
    qe = q;
    re = r;
    return pe * qe * re;
  endfunction

  state_t                 r_state;
  logic                   r_ready, r_valid, r_hit, r_invalid;
  logic signed [W-1:0]    r_a, r_b, r_t;
  logic [2:0][2:0][W-1:0] r_tri;
  logic [1:0][2:0][W-1:0] r_ray;
  logic [1:0]             r_det_idx;
  logic signed [W-1:0]    r_coef, r_da, r_db, r_dt;
  logic                   r_det_ovf;
  logic                   r_div_run;
  logic [1:0]             r_div_sel;
  logic [CW-1:0]          r_bit_cnt;
  logic [N-1:0]           r_dvd;
  logic [W-1:0]           r_rem;
  logic [N-1:0]           r_quo;
  logic                   r_neg;
  logic                   r_div_ovf;

  // ---------------------------------------------------------------- vectors
  wide_t w_t1 [3];
  wide_t w_t2 [3];
  wide_t w_ec [3];
  wide_t w_nd [3];
  wide_t w_ca [3];
  wide_t w_cb [3];
  wide_t w_cc [3];

  for (genvar g = 0; g < 3; g++) begin : g_axis
    assign w_t1[g] = sx(r_tri[1][g]) - sx(r_tri[0][g]);
    assign w_t2[g] = sx(r_tri[2][g]) - sx(r_tri[0][g]);
    assign w_ec[g] = sx(r_ray[1][g]) - sx(r_tri[0][g]);
    assign w_nd[g] = -sx(r_ray[0][g]);
  end

  // The column that Cramer's rule replaces moves with the determinant index.
  always_comb begin
    w_ca = w_t1;
    w_cb = w_t2;
    w_cc = w_nd;
    case (r_det_idx)
      2'd1:    w_ca = w_ec;
      2'd2:    w_cb = w_ec;
      2'd3:    w_cc = w_ec;
      default: ;
    endcase
  end

  // ------------------------------------------------------------ determinant
  // Index 2 is x, 1 is y, 0 is z.
  logic signed [SW-1:0] w_det_sum;
  logic signed [SW-1:0] w_det_shr;
  logic signed [W-1:0]  w_det_res;
  logic                 w_det_ovf;

  assign w_det_sum = tp(w_ca[2], w_cb[1], w_cc[0])
                   + tp(w_cb[2], w_cc[1], w_ca[0])
                   + tp(w_cc[2], w_ca[1], w_cb[0])
                   - tp(w_ca[2], w_cc[1], w_cb[0])
                   - tp(w_cb[2], w_ca[1], w_cc[0])
                   - tp(w_cc[2], w_cb[1], w_ca[0]);
  assign w_det_shr = w_det_sum >>> (2 * FRAC);
  assign w_det_res = w_det_shr[W-1:0];
  // In range only when every bit from W-1 upward is a copy of the sign.
  assign w_det_ovf = !((&w_det_shr[SW-1:W-1]) || !(|w_det_shr[SW-1:W-1]));

  // ---------------------------------------------------------------- divider
  logic [W-1:0]        w_coef_mag;
  logic [1:0]          w_ld_sel;
  logic signed [W-1:0] w_ld_num;
  logic [W-1:0]        w_ld_mag;
  logic [W:0]          w_rem_sh;
  logic                w_ge;
  logic [W-1:0]        w_rem_nx;
  logic [N-1:0]        w_quo_nx;
  logic                w_q_ovf;
  logic signed [W-1:0] w_q_res;

  assign w_coef_mag = r_coef[W-1] ? -r_coef : r_coef;

  // Next numerator: da on the first load, then db, then dt.
  assign w_ld_sel = r_div_run ? r_div_sel + 2'd1 : 2'd0;
  always_comb begin
    w_ld_num = r_dt;
    case (w_ld_sel)
      2'd0:    w_ld_num = r_da;
      2'd1:    w_ld_num = r_db;
      default: w_ld_num = r_dt;
    endcase
  end
  assign w_ld_mag = w_ld_num[W-1] ? -w_ld_num : w_ld_num;

  assign w_rem_sh = {r_rem, r_dvd[N-1]};
  assign w_ge     = w_rem_sh >= {1'b0, w_coef_mag};
  assign w_rem_nx = w_ge ? W'(w_rem_sh - {1'b0, w_coef_mag}) : w_rem_sh[W-1:0];
  assign w_quo_nx = {r_quo[N-2:0], w_ge};

  // Values below only matter on the last bit of a quotient.
  assign w_q_ovf = |w_quo_nx[N-1:W-1];
  assign w_q_res = r_neg ? -w_quo_nx[W-1:0] : w_quo_nx[W-1:0];

  // ------------------------------------------------------------ hit decision
  wide_t w_sum_ab;
  logic  w_fin_hit;
  logic  w_cull_fail;

  assign w_sum_ab  = sx(r_a) + sx(r_b);
  // Evaluated on the edge that finishes t, so t comes from the divider.
  assign w_fin_hit = !w_q_ovf && !r_div_ovf && !r_a[W-1] && !r_b[W-1]
                     && (w_sum_ab <= ONE_Q)
                     && (w_q_res >= MIN_T) && (w_q_res <= MAX_T);

`ifdef TRI_INTERSECT_CULL_EN
  assign w_cull_fail = r_coef[W-1];
`else
  assign w_cull_fail = 1'b0;
`endif

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_hit     <= 1'b0;
      r_invalid <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_t       <= '0;
      r_tri     <= '0;
      r_ray     <= '0;
      r_det_idx <= '0;
      r_coef    <= '0;
      r_da      <= '0;
      r_db      <= '0;
      r_dt      <= '0;
      r_det_ovf <= 1'b0;
      r_div_run <= 1'b0;
      r_div_sel <= '0;
      r_bit_cnt <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_neg     <= 1'b0;
      r_div_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_valid) begin
            r_tri     <= io_bus.i_triangle;
            r_ray     <= io_bus.i_ray;
            r_det_idx <= '0;
            r_det_ovf <= 1'b0;
            r_hit     <= 1'b0;
            r_invalid <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_t       <= '0;
            r_ready   <= 1'b0;
            r_state   <= S_DET;
          end
        end

        S_DET: begin
          case (r_det_idx)
            2'd0:    r_coef <= w_det_res;
            2'd1:    r_da   <= w_det_res;
            2'd2:    r_db   <= w_det_res;
            default: r_dt   <= w_det_res;
          endcase
          if (w_det_ovf) r_det_ovf <= 1'b1;
          r_det_idx <= r_det_idx + 2'd1;
          if (r_det_idx == 2'd3) begin
            r_div_run <= 1'b0;
            r_state   <= S_DIV;
          end
        end

        S_DIV: begin
          if (!r_div_run) begin
            if (r_det_ovf || (r_coef == '0)) begin
              r_invalid <= 1'b1;
              r_valid   <= 1'b1;
              r_state   <= S_DONE;
            end else if (w_cull_fail) begin
              r_valid   <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_div_run <= 1'b1;
              r_div_sel <= 2'd0;
              r_div_ovf <= 1'b0;
              r_dvd     <= N'(w_ld_mag) << FRAC;
              r_rem     <= '0;
              r_quo     <= '0;
              r_bit_cnt <= '0;
              r_neg     <= w_ld_num[W-1] ^ r_coef[W-1];
            end
          end else begin
            r_rem     <= w_rem_nx;
            r_quo     <= w_quo_nx;
            r_dvd     <= r_dvd << 1;
            r_bit_cnt <= r_bit_cnt + CW'(1);
            if (r_bit_cnt == CW'(N - 1)) begin
              case (r_div_sel)
                2'd0:    r_a <= w_q_res;
                2'd1:    r_b <= w_q_res;
                default: r_t <= w_q_res;
              endcase
              if (w_q_ovf) r_div_ovf <= 1'b1;
              if (r_div_sel == 2'd2) begin
                r_invalid <= w_q_ovf || r_div_ovf;
                r_hit     <= w_fin_hit;
                r_valid   <= 1'b1;
                r_div_run <= 1'b0;
                r_state   <= S_DONE;
              end else begin
                // Reload overrides the step assignments above.
                r_div_sel <= r_div_sel + 2'd1;
                r_dvd     <= N'(w_ld_mag) << FRAC;
                r_rem     <= '0;
                r_quo     <= '0;
                r_bit_cnt <= '0;
                r_neg     <= w_ld_num[W-1] ^ r_coef[W-1];
              end
            end
          end
        end

        S_DONE: begin
          if (io_bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.o_ready   = r_ready;
  assign io_bus.o_valid   = r_valid;
  assign io_bus.o_hit     = r_hit;
  assign io_bus.o_invalid = r_invalid;
  assign io_bus.o_a       = r_a;
  assign io_bus.o_b       = r_b;
  assign io_bus.o_t       = r_t;

endmodule

// File: tb/tb_tri_intersect_seq.sv
// Directed bench for tri_intersect_seq, Q16.16 with triangle
// (0,0,0),(1,0,0),(0,1,0). A second instance built with MIN_T=2.0 runs the
// same stimulus in lockstep to exercise the t range limit.
module tb_tri_intersect_seq;
  localparam int          W     = 32;
  localparam logic [31:0] ONE   = 32'h0001_0000;
  localparam logic [31:0] QTR   = 32'h0000_4000;
  localparam logic [31:0] TQ    = 32'h0000_C000;
  localparam logic [31:0] M_ONE = 32'hFFFF_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;

  always #5 clk = ~clk;

  tri_intersect_seq_if #(.W(W)) bus ();
  tri_intersect_seq_if #(.W(W)) bus_mt ();

  tri_intersect_seq #(.W(W), .FRAC(16)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .io_bus(bus)
  );

  tri_intersect_seq #(.W(W), .FRAC(16), .MIN_T(32'sh0002_0000)) dut_mt (
    .i_clk (clk),
    .i_rstn(rstn),
    .io_bus(bus_mt)
  );

  assign bus_mt.i_valid    = bus.i_valid;
  assign bus_mt.i_triangle = bus.i_triangle;
  assign bus_mt.i_ray      = bus.i_ray;
  assign bus_mt.i_ready    = bus.i_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                         input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz);
    bus.i_triangle       = '0;
    bus.i_triangle[1][2] = ONE;
    bus.i_triangle[2][1] = ONE;
    bus.i_ray[1]         = {ex, ey, ez};
    bus.i_ray[0]         = {dx, dy, dz};
  endtask

  // Accept one request and count edges until o_valid rises.
  task automatic run_req(input int exp_lat, input string tag);
    int n;
    n = 0;
    bus.i_valid = 1'b1;
    while (!bus.o_ready && n < 400) begin
      tick();
      n++;
    end
    tick();
    bus.i_valid = 1'b0;
    chk({tag, " accepted"}, 32'(bus.o_ready), 32'd0);
    lat = 0;
    while (!bus.o_valid && lat < 400) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic take_result(input string tag);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(bus.o_valid), 32'd0);
    chk({tag, " ready rise"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    set_req('0, '0, '0, '0, '0, '0);

    #12;
    chk("rst ready",   32'(bus.o_ready),   32'd1);
    chk("rst valid",   32'(bus.o_valid),   32'd0);
    chk("rst hit",     32'(bus.o_hit),     32'd0);
    chk("rst invalid", 32'(bus.o_invalid), 32'd0);
    chk("rst a",       bus.o_a,            32'd0);
    chk("rst t",       bus.o_t,            32'd0);
    rstn = 1'b1;
    tick();

    // Straight hit through the centre of the lower-left quarter.
    set_req(QTR, QTR, ONE, 32'd0, 32'd0, M_ONE);
    run_req(149, "hit");
    chk("hit hit",     32'(bus.o_hit),     32'd1);
    chk("hit invalid", 32'(bus.o_invalid), 32'd0);
    chk("hit a",       bus.o_a,            QTR);
    chk("hit b",       bus.o_b,            QTR);
    chk("hit t",       bus.o_t,            ONE);
    chk("mint valid",  32'(bus_mt.o_valid), 32'd1);
    chk("mint hit",    32'(bus_mt.o_hit),   32'd0);
    chk("mint t",      bus_mt.o_t,          ONE);

    // Backpressure: result must hold, new requests must be ignored.
    set_req(TQ, TQ, ONE, 32'd0, 32'd0, M_ONE);
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = i[0];
      tick();
      chk("bp valid", 32'(bus.o_valid), 32'd1);
      chk("bp ready", 32'(bus.o_ready), 32'd0);
      chk("bp a",     bus.o_a,          QTR);
      chk("bp hit",   32'(bus.o_hit),   32'd1);
    end
    bus.i_valid = 1'b0;
    take_result("bp");

    // Miss: barycentric sum 1.5; accepted on the cycle right after release.
    run_req(149, "miss");
    chk("miss hit",     32'(bus.o_hit),     32'd0);
    chk("miss invalid", 32'(bus.o_invalid), 32'd0);
    chk("miss a",       bus.o_a,            TQ);
    chk("miss b",       bus.o_b,            TQ);
    chk("miss t",       bus.o_t,            ONE);
    take_result("miss");

    // Ray parallel to the triangle plane: coef is zero.
    set_req(QTR, QTR, ONE, ONE, 32'd0, 32'd0);
    run_req(5, "par");
    chk("par invalid", 32'(bus.o_invalid), 32'd1);
    chk("par hit",     32'(bus.o_hit),     32'd0);
    chk("par a",       bus.o_a,            32'd0);
    chk("par b",       bus.o_b,            32'd0);
    chk("par t",       bus.o_t,            32'd0);
    take_result("par");

    // Ray arriving from below: coef is negative.
    set_req(QTR, QTR, M_ONE, 32'd0, 32'd0, ONE);
`ifdef TRI_INTERSECT_CULL_EN
    run_req(5, "back");
    chk("back hit",     32'(bus.o_hit),     32'd0);
    chk("back invalid", 32'(bus.o_invalid), 32'd0);
`else
    run_req(149, "back");
    chk("back hit",     32'(bus.o_hit),     32'd1);
    chk("back invalid", 32'(bus.o_invalid), 32'd0);
    chk("back a",       bus.o_a,            QTR);
    chk("back b",       bus.o_b,            QTR);
    chk("back t",       bus.o_t,            ONE);
`endif
    take_result("back");

    // Reset in the middle of the divide, then a clean request.
    set_req(QTR, QTR, ONE, 32'd0, 32'd0, M_ONE);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    chk("mid busy", 32'(bus.o_ready), 32'd0);
    repeat (50) tick();
    rstn = 1'b0;
    #1;
    chk("mid rst ready",   32'(bus.o_ready),   32'd1);
    chk("mid rst valid",   32'(bus.o_valid),   32'd0);
    chk("mid rst hit",     32'(bus.o_hit),     32'd0);
    chk("mid rst invalid", 32'(bus.o_invalid), 32'd0);
    chk("mid rst a",       bus.o_a,            32'd0);
    #2;
    rstn = 1'b1;
    tick();
    run_req(149, "post");
    chk("post hit", 32'(bus.o_hit), 32'd1);
    chk("post a",   bus.o_a,        QTR);
    chk("post b",   bus.o_b,        QTR);
    chk("post t",   bus.o_t,        ONE);
    take_result("post");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
